// File: rtl/score_pkg.sv
// Shared constants and types for the HUD score panel (score_panel and its helpers).
package score_pkg;

    localparam int          BCD_W      = 4;
    localparam int          COORD_W    = 11;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_WHITE  = 12'hFFF;
    localparam logic [11:0] GLYPH_RGB  = RGB_WHITE;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } score_state_t;

endpackage

// File: rtl/score_bcd_counter.sv
// DIGITS-wide BCD incrementer with ripple carry; holds at all-9s instead of wrapping.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                    clk_25_175,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    all_nines
);

    logic [BCD_W*DIGITS-1:0] bcd_next;
    logic                    carry;

    // Nibble 0 is the LSD; the carry ripples toward the top nibble.
    always_comb begin
        bcd_next  = bcd;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[BCD_W*k +: BCD_W] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (bcd[BCD_W*k +: BCD_W] == 4'd9) begin
                    bcd_next[BCD_W*k +: BCD_W] = 4'd0;
                end else begin
                    bcd_next[BCD_W*k +: BCD_W] = bcd[BCD_W*k +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_25_175) begin
        if (!reset || clr) begin
            bcd <= '0;
        end else if (inc && !all_nines) begin
            bcd <= bcd_next;
        end
    end

endmodule

// File: rtl/score_digit.sv
// Seven-segment glyph for one score cell; cell-relative coordinates in, lit flag out.
// Value 4'hF (or any non-decimal code) renders as an empty cell.
module score_digit
    import score_pkg::*;
#(
    parameter int CELL_W = 56,
    parameter int CELL_H = 41
) (
    input  logic [COORD_W-1:0] rel_x,
    input  logic [COORD_W-1:0] rel_y,
    input  logic [3:0]         value,
    output logic               lit
);

    localparam int SEG_M = 4;
    localparam int SEG_T = 4;
    localparam int MID   = CELL_H / 2;

    localparam logic [COORD_W-1:0] XL0 = COORD_W'(SEG_M);
    localparam logic [COORD_W-1:0] XL1 = COORD_W'(SEG_M + SEG_T);
    localparam logic [COORD_W-1:0] XR0 = COORD_W'(CELL_W - SEG_M - SEG_T);
    localparam logic [COORD_W-1:0] XR1 = COORD_W'(CELL_W - SEG_M);
    localparam logic [COORD_W-1:0] YT0 = COORD_W'(SEG_M);
    localparam logic [COORD_W-1:0] YT1 = COORD_W'(SEG_M + SEG_T);
    localparam logic [COORD_W-1:0] YG0 = COORD_W'(MID - SEG_T / 2);
    localparam logic [COORD_W-1:0] YG1 = COORD_W'(MID - SEG_T / 2 + SEG_T);
    localparam logic [COORD_W-1:0] YB0 = COORD_W'(CELL_H - SEG_M - SEG_T);
    localparam logic [COORD_W-1:0] YB1 = COORD_W'(CELL_H - SEG_M);
    localparam logic [COORD_W-1:0] YMD = COORD_W'(MID);

    // seg = {a, b, c, d, e, f, g}
    logic [6:0] seg;
    logic       x_span, x_left, x_right;
    logic       y_top, y_mid, y_bot, y_upper, y_lower;

    always_comb begin
        case (value)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase

        x_span  = (rel_x >= XL0) && (rel_x < XR1);
        x_left  = (rel_x >= XL0) && (rel_x < XL1);
        x_right = (rel_x >= XR0) && (rel_x < XR1);
        y_top   = (rel_y >= YT0) && (rel_y < YT1);
        y_mid   = (rel_y >= YG0) && (rel_y < YG1);
        y_bot   = (rel_y >= YB0) && (rel_y < YB1);
        y_upper = (rel_y >= YT0) && (rel_y < YMD);
        y_lower = (rel_y >= YMD) && (rel_y < YB1);

        lit = (seg[6] && x_span  && y_top)   ||
              (seg[5] && x_right && y_upper) ||
              (seg[4] && x_right && y_lower) ||
              (seg[3] && x_span  && y_bot)   ||
              (seg[2] && x_left  && y_lower) ||
              (seg[1] && x_left  && y_upper) ||
              (seg[0] && x_span  && y_mid);
    end

endmodule

// File: rtl/score_panel.sv
// HUD score accumulator and renderer: pending pool drains into a BCD counter drawn as glyph cells.
// Optional high-score register is enabled by defining SCORE_HISCORE_EN.
module score_panel
    import score_pkg::*;
#(
    parameter int          DIGITS    = 8,
    parameter int          ADD_W     = 16,
    parameter int          PEND_W    = 21,
    parameter int          DRAIN_DIV = 1,
    parameter int          VERTICAL  = 1,
    parameter int          X0        = 567,
    parameter int          Y0        = 50,
    parameter int          CELL_W    = 56,
    parameter int          CELL_H    = 41,
    parameter int          PITCH     = 46,
    parameter int          BORDER    = 5,
    parameter logic [11:0] FRAME_RGB = 12'h000,
    parameter logic [11:0] OUT_RGB   = 12'hFFF
) (
    input  logic                    clk_25_175,
    input  logic                    reset,
    input  logic [9:0]              hreadwire,
    input  logic [9:0]              vreadwire,
    input  logic [ADD_W-1:0]        score_add,
    input  logic                    clear,
    output logic [11:0]             pixstream,
    output logic [BCD_W*DIGITS-1:0] score_bcd,
    output logic                    busy,
    output logic                    overflow,
`ifdef SCORE_HISCORE_EN
    output logic [BCD_W*DIGITS-1:0] hiscore_bcd,
`endif
    output logic                    state_dbg
);

    localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam int SUM_W = ((PEND_W > ADD_W) ? PEND_W : ADD_W) + 1;
    localparam int SPAN  = (DIGITS - 1) * PITCH;

    localparam logic [PEND_W-1:0]  POOL_MAX = '1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DRAIN_DIV - 1);
    localparam logic [COORD_W-1:0] FX0 = COORD_W'((X0 > BORDER) ? X0 - BORDER : 0);
    localparam logic [COORD_W-1:0] FY0 = COORD_W'((Y0 > BORDER) ? Y0 - BORDER : 0);
    localparam logic [COORD_W-1:0] FX1 = COORD_W'(X0 + ((VERTICAL != 0) ? 0 : SPAN) + CELL_W + BORDER);
    localparam logic [COORD_W-1:0] FY1 = COORD_W'(Y0 + ((VERTICAL != 0) ? SPAN : 0) + CELL_H + BORDER);

    // score_add and clear are one-cycle strobes with no ready: the pool always accepts
    // (saturating), and clear wins over everything in the same cycle.
    score_state_t      state, state_next;
    logic [PEND_W-1:0] pool, pool_next;
    logic [DIV_W-1:0]  div;
    logic [SUM_W-1:0]  pool_sum;
    logic              tick;
    logic              all_nines;

    assign tick      = (state == DRAIN) && (div == DIV_LAST);
    assign busy      = (state == DRAIN);
    assign state_dbg = state;

    always_comb begin
        pool_sum   = SUM_W'(pool) + SUM_W'(score_add) - SUM_W'(tick);
        pool_next  = (pool_sum > SUM_W'(POOL_MAX)) ? POOL_MAX : pool_sum[PEND_W-1:0];
        state_next = (pool_next != '0) ? DRAIN : IDLE;
    end

    always_ff @(posedge clk_25_175) begin
        if (!reset || clear) begin
            state    <= IDLE;
            pool     <= '0;
            div      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            pool  <= pool_next;
            if (tick) begin
                div <= '0;
            end else if (state == DRAIN) begin
                div <= div + DIV_W'(1);
            end
            if (tick && all_nines) begin
                overflow <= 1'b1;
            end
        end
    end

    score_bcd_counter #(
        .DIGITS (DIGITS)
    ) u_counter (
        .clk_25_175 (clk_25_175),
        .reset      (reset),
        .inc        (tick),
        .clr        (clear),
        .bcd        (score_bcd),
        .all_nines  (all_nines)
    );

`ifdef SCORE_HISCORE_EN
    // Valid BCD orders the same as binary, so a plain compare is MSD-first.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            hiscore_bcd <= '0;
        end else if (clear && (score_bcd > hiscore_bcd)) begin
            hiscore_bcd <= score_bcd;
        end
    end
`endif

    logic [COORD_W-1:0] hx, vy, ox, oy, rel_x, rel_y;
    logic [DIGITS-1:0]  shown;
    logic               seen, in_cell, in_frame, glyph_lit;
    logic [3:0]         cell_val;

    assign hx = {1'b0, hreadwire};
    assign vy = {1'b0, vreadwire};

    // Index k counts from the MSD, which lives in the top nibble.
    always_comb begin
        seen = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            seen = seen || (score_bcd[BCD_W*(DIGITS-1-k) +: BCD_W] != 4'd0) || (k == DIGITS - 1);
            shown[k] = seen;
        end
    end

    always_comb begin
        in_cell  = 1'b0;
        rel_x    = '0;
        rel_y    = '0;
        ox       = '0;
        oy       = '0;
        cell_val = BLANK_CODE;
        for (int k = 0; k < DIGITS; k++) begin
            ox = COORD_W'((VERTICAL != 0) ? X0 : X0 + k * PITCH);
            oy = COORD_W'((VERTICAL != 0) ? Y0 + k * PITCH : Y0);
            if (hx >= ox && hx < ox + COORD_W'(CELL_W) &&
                vy >= oy && vy < oy + COORD_W'(CELL_H)) begin
                in_cell  = 1'b1;
                rel_x    = hx - ox;
                rel_y    = vy - oy;
                cell_val = shown[k] ? score_bcd[BCD_W*(DIGITS-1-k) +: BCD_W] : BLANK_CODE;
            end
        end
        in_frame = (hx >= FX0) && (hx < FX1) && (vy >= FY0) && (vy < FY1);
    end

    score_digit #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_digit (
        .rel_x (rel_x),
        .rel_y (rel_y),
        .value (cell_val),
        .lit   (glyph_lit)
    );

    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            pixstream <= RGB_BLACK;
        end else if (in_cell) begin
            pixstream <= glyph_lit ? GLYPH_RGB : FRAME_RGB;
        end else if (in_frame) begin
            pixstream <= FRAME_RGB;
        end else begin
            pixstream <= OUT_RGB;
        end
    end

endmodule
